size_down_unpacker: RTL and testbench

- Read-side consumer of the size-down distributed FIFO.
- Pops IN_WIDTH-bit words from the FIFO read port and emits each word as RATIO narrower slices of OUT_WIDTH = IN_WIDTH/RATIO bits.
- Output is a valid/ready stream with a per-word last flag.
- Runs entirely in the FIFO read clock domain.

---
 rtl/size_down_unpacker.sv | 117 +++++++++++
 tb/tb_size_down_unpacker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/size_down_unpacker.sv
// Pops wide words from a FIFO read port and emits each one as RATIO narrow
// slices on a valid/ready stream, with a last flag on the final slice.
module size_down_unpacker #(
  parameter int IN_WIDTH     = 32,
  parameter int RATIO        = 4,
  parameter int FIFO_OUT_REG = 0,
  parameter int MSB_FIRST    = 1
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  input  logic                         flush,
  input  logic [IN_WIDTH-1:0]          fifo_rd_data,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [IN_WIDTH/RATIO-1:0]    m_data,
  output logic                         m_last,
  output logic [15:0]                  slice_cnt
);

  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                hold_vld_q, hold_vld_d;
  logic                pend_q, pend_d;
  logic [15:0]         slice_cnt_q, slice_cnt_d;

  logic accept;
  logic last_acc;

  assign accept   = hold_vld_q & m_ready;
  assign last_acc = accept & (idx_q == LAST_IDX);

  // A new word may be fetched only when the held one is gone or leaving now.
  assign fifo_rd_en = ~rd_rst & ~flush & ~fifo_empty & ~pend_q
                      & (~hold_vld_q | last_acc);

  always_comb begin
    word_d      = word_q;
    idx_d       = idx_q;
    hold_vld_d  = hold_vld_q;
    pend_d      = pend_q;
    slice_cnt_d = slice_cnt_q;

    if (accept) begin
      slice_cnt_d = slice_cnt_q + 16'd1;
    end

    if (flush) begin
      hold_vld_d = 1'b0;
      idx_d      = '0;
      pend_d     = 1'b0;
    end else begin
      if (accept) begin
        if (last_acc) begin
          hold_vld_d = 1'b0;
          idx_d      = '0;
        end else begin
          word_d = (MSB_FIRST != 0) ? (word_q << OUT_WIDTH) : (word_q >> OUT_WIDTH);
          idx_d  = idx_q + IDX_W'(1);
        end
      end

      if (FIFO_OUT_REG == 0) begin
        if (fifo_rd_en) begin
          word_d     = fifo_rd_data;
          idx_d      = '0;
          hold_vld_d = 1'b1;
        end
      end else begin
        // Registered-output FIFO: data arrives the cycle after the pop.
        if (pend_q) begin
          word_d     = fifo_rd_data;
          idx_d      = '0;
          hold_vld_d = 1'b1;
          pend_d     = 1'b0;
        end
        if (fifo_rd_en) begin
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      word_q      <= '0;
      idx_q       <= '0;
      hold_vld_q  <= 1'b0;
      pend_q      <= 1'b0;
      slice_cnt_q <= '0;
    end else begin
      word_q      <= word_d;
      idx_q       <= idx_d;
      hold_vld_q  <= hold_vld_d;
      pend_q      <= pend_d;
      slice_cnt_q <= slice_cnt_d;
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign m_data = word_q[IN_WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb
      assign m_data = word_q[OUT_WIDTH-1:0];
    end
  endgenerate

  assign m_valid   = hold_vld_q;
  assign m_last    = hold_vld_q & (idx_q == LAST_IDX);
  assign slice_cnt = slice_cnt_q;

endmodule

// File: tb/tb_size_down_unpacker.sv
// Scoreboard bench for size_down_unpacker: three instances (MSB/show-ahead,
// LSB/show-ahead, MSB/registered FIFO) each fed by a small FIFO model.
module tb_size_down_unpacker;

  logic        clk;
  logic        rst_s      [3];
  logic        flush_s    [3];
  logic [31:0] rd_data_s  [3];
  logic        empty_s    [3];
  logic        rd_en_s    [3];
  logic        m_valid_s  [3];
  logic        m_ready_s  [3];
  logic [7:0]  m_data_s   [3];
  logic        m_last_s   [3];
  logic [15:0] slice_cnt_s[3];

  logic [31:0] fq [3][$];
  logic [8:0]  sb [3][$];
  int          pops [3];
  int          n_checks = 0;
  int          n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    size_down_unpacker #(
      .IN_WIDTH    (32),
      .RATIO       (4),
      .FIFO_OUT_REG((gi == 2) ? 1 : 0),
      .MSB_FIRST   ((gi == 1) ? 0 : 1)
    ) u_dut (
      .rd_clk      (clk),
      .rd_rst      (rst_s[gi]),
      .flush       (flush_s[gi]),
      .fifo_rd_data(rd_data_s[gi]),
      .fifo_empty  (empty_s[gi]),
      .fifo_rd_en  (rd_en_s[gi]),
      .m_valid     (m_valid_s[gi]),
      .m_ready     (m_ready_s[gi]),
      .m_data      (m_data_s[gi]),
      .m_last      (m_last_s[gi]),
      .slice_cnt   (slice_cnt_s[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic refresh(input int d);
    empty_s[d] = (fq[d].size() == 0);
    if (d != 2) rd_data_s[d] = (fq[d].size() == 0) ? 32'h0 : fq[d][0];
  endtask

  task automatic push(input int d, input logic [31:0] w);
    logic [7:0] sl;
    fq[d].push_back(w);
    for (int k = 0; k < 4; k++) begin
      sl = (d == 1) ? w[8*k +: 8] : w[31-8*k -: 8];
      sb[d].push_back({(k == 3), sl});
    end
    refresh(d);
  endtask

  task automatic drop_exp(input int d, input int n);
    for (int k = 0; k < n; k++)
      if (sb[d].size() != 0) void'(sb[d].pop_front());
  endtask

  // Advance one clock; pops sampled just before the edge are applied to the FIFO model.
  task automatic cycle();
    logic pop_now [3];
    logic [31:0] w;
    #1;
    for (int d = 0; d < 3; d++) pop_now[d] = rd_en_s[d];
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (pop_now[d]) begin
        n_checks++;
        if (fq[d].size() == 0) begin
          n_fail++;
          $display("FAIL pop_on_empty dut%0d: got rd_en=1 required 0", d);
        end else begin
          w = fq[d].pop_front();
          pops[d]++;
          if (d == 2) rd_data_s[d] = w;
        end
      end
      refresh(d);
    end
  endtask

  task automatic rd_en_is(input int d, input logic exp, input string name);
    #1;
    check(name, {31'd0, rd_en_s[d]}, {31'd0, exp});
  endtask

  // Monitor: compares every accepted slice against the scoreboard.
  always @(negedge clk) begin
    logic [8:0] exp;
    #2;
    for (int d = 0; d < 3; d++) begin
      if (m_valid_s[d] && m_ready_s[d]) begin
        n_checks++;
        if (sb[d].size() == 0) begin
          n_fail++;
          $display("FAIL slice_unexpected dut%0d: got %0h required none", d, m_data_s[d]);
        end else begin
          exp = sb[d].pop_front();
          if ({m_last_s[d], m_data_s[d]} !== exp) begin
            n_fail++;
            $display("FAIL slice dut%0d: got last=%0b data=%0h required last=%0b data=%0h",
                     d, m_last_s[d], m_data_s[d], exp[8], exp[7:0]);
          end else begin
            $display("ok   slice dut%0d: last=%0b data=%0h", d, m_last_s[d], m_data_s[d]);
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1; flush_s[d] = 1'b0; m_ready_s[d] = 1'b1;
      rd_data_s[d] = 32'h0; empty_s[d] = 1'b1; pops[d] = 0;
    end
    @(negedge clk);
    cycle(); cycle();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_valid dut%0d", d), {31'd0, m_valid_s[d]}, 32'd0);
      check($sformatf("reset_data dut%0d", d), {24'd0, m_data_s[d]}, 32'd0);
      check($sformatf("reset_cnt dut%0d", d), {16'd0, slice_cnt_s[d]}, 32'd0);
      rst_s[d] = 1'b0;
    end
    cycle();

    // 1: single word, MSB first, show-ahead
    push(0, 32'hA1B2C3D4);
    check("t1_valid_before", {31'd0, m_valid_s[0]}, 32'd0);
    rd_en_is(0, 1'b1, "t1_pop");
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_valid_%0d", k), {31'd0, m_valid_s[0]}, 32'd1);
      cycle();
    end
    check("t1_valid_after", {31'd0, m_valid_s[0]}, 32'd0);
    check("t1_cnt", {16'd0, slice_cnt_s[0]}, 32'd4);
    check("t1_pops", pops[0], 32'd1);

    // 2: two words back-to-back, LSB first
    push(1, 32'h11223344);
    push(1, 32'h55667788);
    rd_en_is(1, 1'b1, "t2_pop0");
    cycle();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_valid_%0d", k), {31'd0, m_valid_s[1]}, 32'd1);
      if (k == 1) rd_en_is(1, 1'b0, "t2_nopop_mid");
      if (k == 3) rd_en_is(1, 1'b1, "t2_pop_on_last");
      cycle();
    end
    check("t2_valid_after", {31'd0, m_valid_s[1]}, 32'd0);
    check("t2_cnt", {16'd0, slice_cnt_s[1]}, 32'd8);
    check("t2_pops", pops[1], 32'd2);

    // 3: backpressure on the second slice
    push(0, 32'hA1B2C3D4);
    cycle();
    cycle();
    m_ready_s[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t3_hold_data_%0d", k), {24'd0, m_data_s[0]}, 32'h000000B2);
      check($sformatf("t3_hold_valid_%0d", k), {31'd0, m_valid_s[0]}, 32'd1);
      cycle();
    end
    check("t3_hold_last", {31'd0, m_last_s[0]}, 32'd0);
    m_ready_s[0] = 1'b1;
    cycle(); cycle(); cycle();
    check("t3_valid_after", {31'd0, m_valid_s[0]}, 32'd0);
    check("t3_cnt", {16'd0, slice_cnt_s[0]}, 32'd8);
    check("t3_pops", pops[0], 32'd2);

    // 4: registered-output FIFO
    push(2, 32'hA1B2C3D4);
    push(2, 32'h5A6B7C8D);
    rd_en_is(2, 1'b1, "t4_pop0");
    cycle();
    check("t4_latency_gap", {31'd0, m_valid_s[2]}, 32'd0);
    rd_en_is(2, 1'b0, "t4_nopop_pend");
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_w0_valid_%0d", k), {31'd0, m_valid_s[2]}, 32'd1);
      if (k == 3) rd_en_is(2, 1'b1, "t4_pop1");
      cycle();
    end
    check("t4_idle", {31'd0, m_valid_s[2]}, 32'd0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_w1_valid_%0d", k), {31'd0, m_valid_s[2]}, 32'd1);
      cycle();
    end
    check("t4_valid_after", {31'd0, m_valid_s[2]}, 32'd0);
    check("t4_cnt", {16'd0, slice_cnt_s[2]}, 32'd8);

    // 5: reset mid-word
    push(0, 32'hDEADBEEF);
    cycle(); cycle(); cycle();
    rst_s[0] = 1'b1;
    m_ready_s[0] = 1'b0;
    drop_exp(0, 2);
    push(0, 32'h0F1E2D3C);
    rd_en_is(0, 1'b0, "t5_nopop_rst0");
    cycle();
    check("t5_valid", {31'd0, m_valid_s[0]}, 32'd0);
    check("t5_data", {24'd0, m_data_s[0]}, 32'd0);
    check("t5_last", {31'd0, m_last_s[0]}, 32'd0);
    check("t5_cnt", {16'd0, slice_cnt_s[0]}, 32'd0);
    rd_en_is(0, 1'b0, "t5_nopop_rst1");
    cycle();
    check("t5_pops", pops[0], 32'd3);
    rst_s[0] = 1'b0;
    m_ready_s[0] = 1'b1;
    rd_en_is(0, 1'b1, "t5_pop_release");
    cycle();
    for (int k = 0; k < 4; k++) cycle();
    check("t5_cnt_after", {16'd0, slice_cnt_s[0]}, 32'd4);

    // 6: flush during the third slice
    push(0, 32'h01234567);
    push(0, 32'h89ABCDEF);
    cycle(); cycle(); cycle();
    check("t6_third", {24'd0, m_data_s[0]}, 32'h00000045);
    flush_s[0] = 1'b1;
    m_ready_s[0] = 1'b0;
    drop_exp(0, 2);
    rd_en_is(0, 1'b0, "t6_nopop_flush");
    cycle();
    flush_s[0] = 1'b0;
    m_ready_s[0] = 1'b1;
    check("t6_valid_off", {31'd0, m_valid_s[0]}, 32'd0);
    check("t6_cnt_kept", {16'd0, slice_cnt_s[0]}, 32'd6);
    rd_en_is(0, 1'b1, "t6_pop_after");
    cycle();
    check("t6_next_first", {24'd0, m_data_s[0]}, 32'h00000089);
    for (int k = 0; k < 4; k++) cycle();
    check("t6_valid_after", {31'd0, m_valid_s[0]}, 32'd0);
    check("t6_cnt_after", {16'd0, slice_cnt_s[0]}, 32'd10);

    cycle();
    for (int d = 0; d < 3; d++)
      check($sformatf("sb_drained dut%0d", d), sb[d].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
